// File: rtl/uop_queue.sv
// uop_queue: decoupling FIFO between the frontend and rename/dispatch.
//   Captures at most one decoded uop per cycle and presents the two oldest
//   uops (slot 0 = oldest, slot 1 = next) to the consumer. It also generates
//   the frontend stall, keeping SKID entries of headroom for uops still in
//   flight. A flush (resteer) empties the queue.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       resteer; empties the queue, dominant over push/pop
//   valid_in, *_in              push request and uop fields
//   deq_cnt                     uops consumed this cycle (3 behaves as 2)
//   valid0_out/valid1_out       slot occupancy flags
//   *0_out, *1_out              slot 0 / slot 1 copies of every uop field
//   stall_out                   registered stall to the frontend
//   count_out                   occupancy, 0..DEPTH
//   overflow_err                sticky: a push was dropped because the queue was full
module uop_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned UOP_W = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [UOP_W-1:0]           uop_in,
  input  logic                       eoi_in,
  input  logic [4:0]                 dr_in,
  input  logic [4:0]                 sr1_in,
  input  logic [4:0]                 sr2_in,
  input  logic [XLEN-1:0]            imm_in,
  input  logic                       use_imm_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic                       exception_in,
  input  logic [9:0]                 bhr_in,
  output logic                       stall_out,
  input  logic [1:0]                 deq_cnt,
  output logic                       valid0_out,
  output logic                       valid1_out,
  output logic [UOP_W-1:0]           uop0_out,
  output logic                       eoi0_out,
  output logic [4:0]                 dr0_out,
  output logic [4:0]                 sr10_out,
  output logic [4:0]                 sr20_out,
  output logic [XLEN-1:0]            imm0_out,
  output logic                       use_imm0_out,
  output logic [XLEN-1:0]            pc0_out,
  output logic                       exception0_out,
  output logic [9:0]                 bhr0_out,
  output logic [UOP_W-1:0]           uop1_out,
  output logic                       eoi1_out,
  output logic [4:0]                 dr1_out,
  output logic [4:0]                 sr11_out,
  output logic [4:0]                 sr21_out,
  output logic [XLEN-1:0]            imm1_out,
  output logic                       use_imm1_out,
  output logic [XLEN-1:0]            pc1_out,
  output logic                       exception1_out,
  output logic [9:0]                 bhr1_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = UOP_W + 1 + 5 + 5 + 5 + XLEN + 1 + XLEN + 1 + 10;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - SKID);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_stall;
  logic          r_ovf;

  logic [EW-1:0] w_wr_data;
  logic [PW-1:0] w_head1;
  logic [CW-1:0] w_deq_req;
  logic [CW-1:0] w_eff_deq;
  logic          w_full;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;

  assign w_wr_data = {uop_in, eoi_in, dr_in, sr1_in, sr2_in, imm_in,
                      use_imm_in, pc_in, exception_in, bhr_in};

  // Read side: slot 1 index wraps on its own through the PW-bit add
  assign w_head1 = r_head + 1'b1;
  assign {uop0_out, eoi0_out, dr0_out, sr10_out, sr20_out, imm0_out,
          use_imm0_out, pc0_out, exception0_out, bhr0_out} = r_mem[r_head];
  assign {uop1_out, eoi1_out, dr1_out, sr11_out, sr21_out, imm1_out,
          use_imm1_out, pc1_out, exception1_out, bhr1_out} = r_mem[w_head1];
  assign valid0_out   = (r_count >= CW'(1));
  assign valid1_out   = (r_count >= CW'(2));
  assign count_out    = r_count;
  assign stall_out    = r_stall;
  assign overflow_err = r_ovf;

  // Pop request clamps to 2, then to what is actually stored
  assign w_deq_req = (deq_cnt == 2'd0) ? CW'(0) :
                     (deq_cnt == 2'd1) ? CW'(1) : CW'(2);
  assign w_eff_deq = (w_deq_req > r_count) ? r_count : w_deq_req;

  // Full test uses the current count: a same-cycle pop does not make room
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = valid_in & ~flush & ~w_full;
  assign w_count_nxt = flush ? CW'(0) : (r_count + CW'(w_push) - w_eff_deq);

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        r_head <= r_head + PW'(w_eff_deq);
        if (w_push)
          r_tail <= r_tail + 1'b1;
        if (valid_in && w_full)
          r_ovf <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_stall <= (w_count_nxt >= STALL_TH);
    end
  end

  // Storage: not reset, not cleared on flush
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= w_wr_data;
  end

endmodule
